// File: rtl/ddr5_req_intake_queue.sv
// ---------------------------------------------------------------------------
// ddr5_req_intake_queue
// Intake stage of the DDR5 command scheduler. It gates each CPU trace request
// on its arrival timestamp, decodes the physical address into DDR5 topology
// fields, and buffers the result in an in-order queue. The scheduler pops
// entries from the head of that queue.
//
// Ports
//   clk, rst_n        : CPU-domain clock; asynchronous active-low reset
//   in_valid/in_ready : request handshake. in_ready = !full && now >= in_time
//   in_time           : arrival timestamp, in CPU cycles
//   in_core           : core ID of the issuing core
//   in_op             : 0=read, 1=write, 2=ifetch, 3=illegal (dropped)
//   in_addr           : 36-bit physical address; bits [35:34] are ignored
//   out_valid/out_pop : head-of-queue handshake towards the scheduler
//   out_*             : decoded fields and age of the head entry
//   now               : free-running CPU cycle counter
//   count/full/empty  : queue occupancy
//   err_drop          : one-cycle pulse after an illegal op is consumed
//
// Optional feature
//   REQQ_FASTFWD_EN : when the queue is empty and the offered request lies
//                     in the future, now jumps straight to in_time. This
//                     skips idle gaps in the trace.
// ---------------------------------------------------------------------------
module ddr5_req_intake_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CORE_W = 4,
  parameter int unsigned AGE_W  = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_time,
  input  logic [CORE_W-1:0] in_core,
  input  logic [1:0]        in_op,
  input  logic [35:0]       in_addr,
  output logic              out_valid,
  input  logic              out_pop,
  output logic [31:0]       out_time,
  output logic [CORE_W-1:0] out_core,
  output logic [1:0]        out_op,
  output logic [15:0]       out_row,
  output logic [9:0]        out_col,
  output logic [1:0]        out_bank,
  output logic [2:0]        out_bg,
  output logic              out_channel,
  output logic [1:0]        out_byte_sel,
  output logic [AGE_W-1:0]  out_age,
  output logic [31:0]       now,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              err_drop
);

  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  // One stored request, already decoded into DDR5 topology fields.
  typedef struct packed {
    logic [31:0]       t;
    logic [CORE_W-1:0] core;
    logic [1:0]        op;
    logic [15:0]       row;
    logic [9:0]        col;
    logic [1:0]        bank;
    logic [2:0]        bg;
    logic              channel;
    logic [1:0]        byte_sel;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      now_q, now_d;
  logic             full_q, empty_q, err_q;
  logic             accept, push, pop, drop;
  entry_t           wr_entry;
  entry_t           mem [DEPTH];
  logic [AGE_W-1:0] age [DEPTH];
  logic             unused_addr_hi;

  // The two top address bits do not map to any DDR5 field.
  assign unused_addr_hi = ^in_addr[35:34];

  // Request handshake. Holding it low during reset keeps stale trace requests out.
  assign in_ready = rst_n && !full_q && (now_q >= in_time);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_op != OP_ILLEGAL);
  assign drop     = accept && (in_op == OP_ILLEGAL);
  assign pop      = out_pop && !empty_q;

  // Address decode into row / column / bank / bank group / channel / byte.
  always_comb begin
    wr_entry          = '0;
    wr_entry.t        = in_time;
    wr_entry.core     = in_core;
    wr_entry.op       = in_op;
    wr_entry.row      = in_addr[33:18];
    wr_entry.col      = {in_addr[17:12], in_addr[5:2]};
    wr_entry.bank     = in_addr[11:10];
    wr_entry.bg       = in_addr[9:7];
    wr_entry.channel  = in_addr[6];
    wr_entry.byte_sel = in_addr[1:0];
  end

  // Occupancy. A full queue never pushes, so push and pop together keep it steady.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Next value of the cycle counter.
  always_comb begin
    now_d = now_q + 32'd1;
`ifdef REQQ_FASTFWD_EN
    if (empty_q && in_valid && (in_time > now_q)) begin
      now_d = in_time;
    end
`endif
  end

  // Control state: pointers, occupancy flags, time base, drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      now_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(DEPTH));
      empty_q <= (cnt_d == '0);
      now_q   <= now_d;
      err_q   <= drop;
    end
  end

  // Entry payload storage. Contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  // Saturating per-entry age. Slots that are not valid also count, but a
  // slot is cleared to zero whenever it is written, so only valid ages are seen.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr_q == PTR_W'(i))) begin
        age[i] <= '0;
      end else if (age[i] != '1) begin
        age[i] <= age[i] + AGE_W'(1);
      end
    end
  end

  // Head-of-queue view.
  assign out_valid    = !empty_q;
  assign out_time     = mem[rd_ptr_q].t;
  assign out_core     = mem[rd_ptr_q].core;
  assign out_op       = mem[rd_ptr_q].op;
  assign out_row      = mem[rd_ptr_q].row;
  assign out_col      = mem[rd_ptr_q].col;
  assign out_bank     = mem[rd_ptr_q].bank;
  assign out_bg       = mem[rd_ptr_q].bg;
  assign out_channel  = mem[rd_ptr_q].channel;
  assign out_byte_sel = mem[rd_ptr_q].byte_sel;
  assign out_age      = age[rd_ptr_q];

  assign now      = now_q;
  assign count    = cnt_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign err_drop = err_q;

endmodule

// File: tb/tb_ddr5_req_intake_queue.sv
// Scoreboard bench for ddr5_req_intake_queue. The driver predicts acceptance
// from a reference model (cycle count plus a queue of expected entries) and
// queues the decoded expectations. The monitor checks the head and the status
// outputs every cycle and pops its queue when the head is consumed.
module tb_ddr5_req_intake_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_time = '0;
  logic [3:0]  in_core = '0;
  logic [1:0]  in_op = '0;
  logic [35:0] in_addr = '0;
  logic        out_valid;
  logic        out_pop = 1'b0;
  logic [31:0] out_time;
  logic [3:0]  out_core;
  logic [1:0]  out_op;
  logic [15:0] out_row;
  logic [9:0]  out_col;
  logic [1:0]  out_bank;
  logic [2:0]  out_bg;
  logic        out_channel;
  logic [1:0]  out_byte_sel;
  logic [7:0]  out_age;
  logic [31:0] now;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        err_drop;

  ddr5_req_intake_queue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
    .in_core(in_core), .in_op(in_op), .in_addr(in_addr),
    .out_valid(out_valid), .out_pop(out_pop), .out_time(out_time),
    .out_core(out_core), .out_op(out_op), .out_row(out_row),
    .out_col(out_col), .out_bank(out_bank), .out_bg(out_bg),
    .out_channel(out_channel), .out_byte_sel(out_byte_sel),
    .out_age(out_age), .now(now), .count(count), .full(full),
    .empty(empty), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] t;
    logic [3:0]  core;
    logic [1:0]  op;
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        ch;
    logic [1:0]  bs;
    int          enq;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mnow = '0;
  int          cyc = 0;
  logic        drop_exp = 1'b0;
  logic        mon_en = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle. Acceptance is predicted by the model, and expectations
  // are queued after the edge.
  task automatic step(input logic v, input logic [31:0] t, input logic [3:0] c,
                      input logic [1:0] op, input logic [35:0] a, input logic p,
                      output logic acc, output logic [31:0] acc_now);
    exp_t e;
    logic rdy;
    @(negedge clk);
    in_valid = v; in_time = t; in_core = c; in_op = op; in_addr = a; out_pop = p;
    #1;
    rdy = (sb.size() < DEPTH) && (mnow >= t);
    chk("in_ready", in_ready, rdy);
    acc = v && rdy;
    acc_now = mnow;
    e.t = t; e.core = c; e.op = op; e.enq = cyc;
    e.row  = 16'((a / 36'd262144) % 36'd65536);
    e.col  = 10'((((a / 36'd4096) % 36'd64) * 36'd16) + ((a / 36'd4) % 36'd16));
    e.bank = 2'((a / 36'd1024) % 36'd4);
    e.bg   = 3'((a / 36'd128) % 36'd8);
    e.ch   = 1'((a / 36'd64) % 36'd2);
    e.bs   = 2'(a % 36'd4);
    @(posedge clk);
    #1;
    if (acc && op != 2'd3) sb.push_back(e);
    drop_exp = acc && (op == 2'd3);
    in_valid = 1'b0; out_pop = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a; logic [31:0] an;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 2'd0, 36'd0, 1'b0, a, an);
  endtask

  task automatic drain();
    logic a; logic [31:0] an;
    int k = 0;
    while (sb.size() > 0 && k < 40) begin
      step(1'b0, 32'd0, 4'd0, 2'd0, 36'd0, 1'b1, a, an);
      k++;
    end
    chk("drain_empty", empty, 1'b1);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    in_valid = 1'b1; in_time = 32'd0; out_pop = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_count", count, 5'd0);
    chk("rst_now", now, 32'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err_drop", err_drop, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_now", now, 32'd0);
    chk("rst_hold_count", count, 5'd0);
    in_valid = 1'b0; out_pop = 1'b0;
    sb.delete();
    mnow = '0;
    drop_exp = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compare the status outputs and the head against the scoreboard,
  // then advance the model time base.
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("count", count, 64'(sb.size()));
      chk("empty", empty, sb.size() == 0);
      chk("full", full, sb.size() == DEPTH);
      chk("out_valid", out_valid, sb.size() != 0);
      chk("now", now, mnow);
      chk("err_drop", err_drop, drop_exp);
      if (out_valid && sb.size() > 0) begin
        int ea;
        ea = cyc - sb[0].enq - 1;
        if (ea > 255) ea = 255;
        chk("head_time", out_time, sb[0].t);
        chk("head_core", out_core, sb[0].core);
        chk("head_op", out_op, sb[0].op);
        chk("head_row", out_row, sb[0].row);
        chk("head_col", out_col, sb[0].col);
        chk("head_bank", out_bank, sb[0].bank);
        chk("head_bg", out_bg, sb[0].bg);
        chk("head_channel", out_channel, sb[0].ch);
        chk("head_byte_sel", out_byte_sel, sb[0].bs);
        chk("head_age", out_age, 64'(ea));
      end
`ifdef REQQ_FASTFWD_EN
      if (sb.size() == 0 && in_valid && in_time > mnow) mnow = in_time;
      else mnow = mnow + 32'd1;
`else
      mnow = mnow + 32'd1;
`endif
      if (out_pop && sb.size() > 0) void'(sb.pop_front());
      cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [31:0] an, t;
    int k;
    logic [1:0] op;
    rst_n = 1'b1;
    #3;
    do_reset();

    // Timestamp gating and address decode.
    acc = 1'b0; k = 0;
    while (!acc && k < 20) begin
      step(1'b1, 32'd5, 4'd3, 2'd0, 36'h0_0004_0C8F, 1'b0, acc, an);
      k++;
    end
    chk("gate_accept_now", an, 32'd5);
    chk("gate_out_valid", out_valid, 1'b1);
    chk("gate_row", out_row, 16'h0001);
    chk("gate_bank", out_bank, 2'b11);
    chk("gate_bg", out_bg, 3'b001);
    chk("gate_channel", out_channel, 1'b0);
    chk("gate_col", out_col, 10'h003);
    chk("gate_byte_sel", out_byte_sel, 2'b11);
    drain();

    // Fill to full, block the 17th, then release it with a pop.
    for (int i = 0; i < 16; i++)
      step(1'b1, 32'd0, 4'($urandom), 2'($urandom_range(0, 2)), 36'($urandom) ^ 36'h3_0000_0000, 1'b0, acc, an);
    chk("fill_count", count, 5'd16);
    chk("fill_full", full, 1'b1);
    step(1'b1, 32'd0, 4'd1, 2'd1, 36'h1234, 1'b0, acc, an);
    chk("full_block_count", count, 5'd16);
    step(1'b1, 32'd0, 4'd1, 2'd1, 36'h1234, 1'b1, acc, an);
    chk("full_pop_count", count, 5'd15);
    step(1'b1, 32'd0, 4'd1, 2'd1, 36'h1234, 1'b0, acc, an);
    chk("full_refill_count", count, 5'd16);
    drain();

    // Simultaneous push/pop at count 8 keeps FIFO order.
    for (int i = 0; i < 8; i++)
      step(1'b1, 32'(i), 4'(i), 2'd0, 36'($urandom), 1'b0, acc, an);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 32'(8 + i), 4'(i), 2'd1, 36'($urandom), 1'b1, acc, an);
      chk("pp_count", count, 5'd8);
      chk("pp_head_time", out_time, 32'(i + 1));
    end

    // Illegal op is consumed, not stored, and pulses err_drop once.
    step(1'b1, 32'd0, 4'd2, 2'd3, 36'h0_0000_0040, 1'b0, acc, an);
    chk("illegal_err_drop", err_drop, 1'b1);
    chk("illegal_count", count, 5'd8);
    idle(1);
    chk("illegal_err_drop_clear", err_drop, 1'b0);
    drain();

    // Age saturation, then reset to zero on a fresh entry.
    step(1'b1, 32'd0, 4'd5, 2'd2, 36'h0_ABCD_1234, 1'b0, acc, an);
    idle(300);
    chk("age_saturated", out_age, 8'd255);
    step(1'b0, 32'd0, 4'd0, 2'd0, 36'd0, 1'b1, acc, an);
    step(1'b1, 32'd0, 4'd6, 2'd0, 36'h0_0000_0100, 1'b0, acc, an);
    chk("age_fresh", out_age, 8'd0);
    drain();

    // Large trace gap from now=10.
    do_reset();
    idle(10);
    acc = 1'b0; k = 0;
    while (!acc && k < 1100) begin
      step(1'b1, 32'd1000, 4'd7, 2'd0, 36'h0_0000_0400, 1'b0, acc, an);
      k++;
    end
    chk("gap_accept_now", an, 32'd1000);
`ifdef REQQ_FASTFWD_EN
    chk("gap_offers", 64'(k), 64'd2);
`else
    chk("gap_offers", 64'(k), 64'd991);
`endif
    drain();

    // Randomized traffic with one mid-stream reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      t = (mnow >= 32'd2) ? mnow - 32'd2 + 32'($urandom_range(0, 4)) : 32'($urandom_range(0, 1));
      op = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      step($urandom_range(0, 9) < 6, t, 4'($urandom), op,
           {4'($urandom), 32'($urandom)}, $urandom_range(0, 9) < 4, acc, an);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr5_req_intake_queue.md
Name: ddr5_req_intake_queue

Overview:
- Upstream stage of the DDR5 command scheduler: accepts CPU trace requests (time, core, op, 36-bit address), gates each request on its CPU-cycle timestamp, and decodes the address into DDR5 topological fields.
- Buffers up to 16 requests in an in-order queue with per-entry age tracking.
- Presents the head entry to the scheduler, which pops it.

Parameters:
- DEPTH, 16, queue capacity in entries; power of two.
- CORE_W, 4, width of the core ID field.
- AGE_W, 8, width of the per-entry saturating age counter.

Ports:
- clk  in  1  system clock (CPU clock domain)
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request offered
- in_ready  out  1  request accepted this cycle when in_valid is also high
- in_time  in  32  request arrival time, CPU clock cycles
- in_core  in  CORE_W  issuing core
- in_op  in  2  0=read, 1=write, 2=ifetch, 3=illegal
- in_addr  in  36  physical address
- out_valid  out  1  head entry valid
- out_pop  in  1  scheduler consumes the head
- out_time  out  32  head arrival time
- out_core  out  CORE_W  head core
- out_op  out  2  head op
- out_row  out  16  addr[33:18]
- out_col  out  10  {addr[17:12], addr[5:2]}
- out_bank  out  2  addr[11:10]
- out_bg  out  3  addr[9:7]
- out_channel  out  1  addr[6]
- out_byte_sel  out  2  addr[1:0]
- out_age  out  AGE_W  head age in cycles since enqueue
- now  out  32  free-running CPU cycle counter
- count  out  5  occupancy, 0..16
- full  out  1  count==DEPTH
- empty  out  1  count==0
- err_drop  out  1  one-cycle pulse when an illegal op is consumed

Behaviour:
- Reset values: now=0, count=0, empty=1, full=0, out_valid=0, err_drop=0, in_ready=0 during reset. Read/write pointers=0. Entry contents are don't-care.
- now increments by 1 every clk and wraps modulo 2^32. Time compare is unsigned, with no wrap handling.
- in_ready = !full && (now >= in_time). This is combinational from registered state and in_time.
- Accept (in_valid && in_ready) with in_op!=3:
  - Store the decoded fields at the write pointer and set that entry's age=0.
  - Advance the write pointer modulo DEPTH and increment count.
- Accept with in_op==3:
  - Request is consumed but not stored; count is unchanged.
  - err_drop pulses high the next cycle.
- addr[35:34] are ignored.
- Latency: a request accepted in cycle N appears on out_* with out_valid=1 in cycle N+1 at the earliest, when the queue was empty.
- out_valid = !empty. The out_* fields always reflect the entry at the read pointer.
- Pop (out_pop && out_valid): advance the read pointer and decrement count. out_pop while empty is ignored with no state change.
- Simultaneous accept and pop: count is unchanged and both pointers advance.
- Full: in_ready=0 even if out_pop is high that cycle; no push-through.
- Age: every valid entry's age increments by 1 per cycle and saturates at 2^AGE_W-1. A newly written entry starts at 0.
- Asynchronous reset mid-operation flushes the queue immediately and restarts now at 0. Requests in flight are lost.

Optional Feature:
- Macro: REQQ_FASTFWD_EN.
- With the macro defined, when empty && in_valid && in_time > now, the next cycle loads now <= in_time instead of now+1. This skips idle trace gaps. The request is then accepted the following cycle.
- Without the macro, now always increments by 1.

Test Plan:
- Timestamp gating: reset, then offer in_time=5, addr=36'h0_0004_0C8F, op=0. Required: in_ready=0 while now<5; accepted at now=5. Next cycle: out_valid=1, out_row=16'h0001, out_bank=2'b11, out_bg=3'b001, out_channel=0, out_col=10'h003, out_byte_sel=2'b11.
- Fill and full: offer 17 requests with in_time=0 and no pops. Required: count=16, full=1, in_ready=0 on the 17th; one pop then lets the 17th be accepted the next cycle.
- Simultaneous push/pop at count=8: count stays 8, and the head advances in FIFO order (check out_time sequence 0,1,2...).
- Illegal op: in_op=3 accepted. Required: err_drop=1 for exactly one cycle and count unchanged.
- Age saturation: enqueue one entry and hold with no pops for 300 cycles. Required: out_age=255 from cycle 255 onward; a pop then a fresh push gives out_age=0.
- Fast-forward (macro defined): empty queue, now=10, offer in_time=1000. Required: now=1000 next cycle and the request accepted in that cycle. Without the macro, acceptance occurs at now=1000 after counting.
